// File: rtl/disp_pkg.sv
// disp_pkg: display view codes, FSM state type and timer width shared by the display arbiter.
package disp_pkg;
  localparam logic [2:0] VIEW_TIME   = 3'b000;
  localparam logic [2:0] VIEW_CAL    = 3'b100;
  localparam logic [2:0] VIEW_ALM    = 3'b010;
  localparam logic [2:0] VIEW_BANNER = 3'b001;
  localparam int TIMER_W = 28;
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PEEK   = 2'b01,
    S_SET    = 2'b10,
    S_BANNER = 2'b11
  } state_e;
endpackage

// File: rtl/display_arbiter_hold_timer.sv
// hold_timer: 28-bit down-counter for a timed view.
// Ports: clk, rst_n (async active-low), load_i (start at CYCLES-1), abort_i (stop),
// busy_o (counting), done_o (busy and at 0: last cycle of the view).
module hold_timer
  import disp_pkg::*;
#(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic abort_i,
  output logic busy_o,
  output logic done_o
);
  logic [TIMER_W-1:0] cnt_q;
  logic               busy_q;
  assign done_o = busy_q && cnt_q == '0;
  assign busy_o = busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= TIMER_W'(CYCLES - 1);
      busy_q <= 1'b1;
    end else if (abort_i || done_o) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: chooses the display view from peek keys, set-mode levels and serial updates.
// Ports: clk, reset (async active-low), key_cal/key_alm (active-low buttons),
// set_time/set_cal/set_alarm (set levels), uart_upd (update pulse),
// sel (view: 000 time, 100 cal, 010 alarm, 001 banner), state (FSM), hold_busy (timer running).
// DISP_ALARM_RING_EN adds alarm_ring (forces alarm view outside SET) and blink output.
module display_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 150000000
`ifdef DISP_ALARM_RING_EN
  , parameter int unsigned BLINK_CYCLES = 25000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_cal,
  input  logic       key_alm,
  input  logic       set_time,
  input  logic       set_cal,
  input  logic       set_alarm,
  input  logic       uart_upd,
`ifdef DISP_ALARM_RING_EN
  input  logic       alarm_ring,
  output logic       blink,
`endif
  output logic [2:0] sel,
  output logic [1:0] state,
  output logic       hold_busy
);
  state_e     state_q, state_d;
  logic [2:0] view_q, view_d;
  logic       kc_q, ka_q, pend_q, pend_d;
  logic       load, abort, done;
  logic       cal_edge, alm_edge, any_edge, any_set;
  logic [2:0] set_view, key_view;
  assign cal_edge = kc_q & ~key_cal;
  assign alm_edge = ka_q & ~key_alm;
  assign any_edge = cal_edge | alm_edge;
  assign any_set  = set_time | set_cal | set_alarm;
  assign set_view = set_time ? VIEW_TIME : set_cal ? VIEW_CAL : VIEW_ALM;
  assign key_view = cal_edge ? VIEW_CAL : VIEW_ALM;
  always_comb begin
    state_d = state_q;
    view_d  = view_q;
    load    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_set) begin
          state_d = S_SET;
          view_d  = set_view;
        end else if (any_edge) begin
          state_d = S_PEEK;
          view_d  = key_view;
          load    = 1'b1;
        end else if (uart_upd || pend_q) begin
          state_d = S_BANNER;
          view_d  = VIEW_BANNER;
          load    = 1'b1;
        end
      end
      S_PEEK: begin
        if (any_set) begin
          state_d = S_SET;
          view_d  = set_view;
          abort   = 1'b1;
        end else if (any_edge) begin
          view_d  = key_view;
          load    = 1'b1;
        end else if (done) begin
          state_d = S_IDLE;
          view_d  = VIEW_TIME;
        end
      end
      S_SET: begin
        state_d = any_set ? S_SET : S_IDLE;
        view_d  = any_set ? set_view : VIEW_TIME;
      end
      S_BANNER: begin
        if (any_set) begin
          state_d = S_SET;
          view_d  = set_view;
          abort   = 1'b1;
        end else if (any_edge) begin
          state_d = S_PEEK;
          view_d  = key_view;
          load    = 1'b1;
        end else if (uart_upd) begin
          load    = 1'b1;
        end else if (done) begin
          state_d = S_IDLE;
          view_d  = VIEW_TIME;
        end
      end
    endcase
  end
  // An update that does not start or extend a banner is remembered, never dropped.
  assign pend_d = (state_d == S_BANNER && state_q != S_BANNER) ? 1'b0 :
                  (uart_upd && state_d != S_BANNER) ? 1'b1 : pend_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      view_q  <= VIEW_TIME;
      pend_q  <= 1'b0;
      kc_q    <= 1'b1;
      ka_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      view_q  <= view_d;
      pend_q  <= pend_d;
      kc_q    <= key_cal;
      ka_q    <= key_alm;
    end
  end
  hold_timer #(.CYCLES(HOLD_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (load),
    .abort_i (abort),
    .busy_o  (hold_busy),
    .done_o  (done)
  );
  assign state = state_q;
`ifdef DISP_ALARM_RING_EN
  logic [TIMER_W-1:0] bcnt_q;
  logic               blink_q;
  logic [2:0]         sel_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      sel_q   <= VIEW_TIME;
    end else begin
      sel_q <= (alarm_ring && state_d != S_SET) ? VIEW_ALM : view_d;
      if (!alarm_ring) begin
        bcnt_q  <= '0;
        blink_q <= 1'b0;
      end else if (bcnt_q == TIMER_W'(BLINK_CYCLES - 1)) begin
        bcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt_q  <= bcnt_q + 1'b1;
      end
    end
  end
  assign sel   = sel_q;
  assign blink = blink_q;
`else
  assign sel = view_q;
`endif
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed and random checks of display_arbiter against a cycles-left view model.
module tb_display_arbiter;
  localparam int H = 8;
  localparam int B = 3;
  logic clk = 0, reset = 0, key_cal = 1, key_alm = 1;
  logic set_time = 0, set_cal = 0, set_alarm = 0, uart_upd = 0;
  logic [2:0] sel;
  logic [1:0] state;
  logic       hold_busy;
`ifdef DISP_ALARM_RING_EN
  logic alarm_ring = 0, blink;
`endif
  display_arbiter #(
    .HOLD_CYCLES(H)
`ifdef DISP_ALARM_RING_EN
    , .BLINK_CYCLES(B)
`endif
  ) dut (
    .clk(clk), .reset(reset), .key_cal(key_cal), .key_alm(key_alm),
    .set_time(set_time), .set_cal(set_cal), .set_alarm(set_alarm), .uart_upd(uart_upd),
`ifdef DISP_ALARM_RING_EN
    .alarm_ring(alarm_ring), .blink(blink),
`endif
    .sel(sel), .state(state), .hold_busy(hold_busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int m_state, m_left, m_bc;
  logic [2:0] m_view, m_sel;
  logic m_pend, pk_cal, pk_alm, m_blink;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0; m_left = 0; m_view = 0; m_sel = 0; m_pend = 0;
    pk_cal = 1; pk_alm = 1; m_blink = 0; m_bc = 0;
  endtask
  task automatic model_step();
    bit ce, ae;
    int ns;
    ce = pk_cal && !key_cal;
    ae = pk_alm && !key_alm;
    ns = m_state;
    if (set_time || set_cal || set_alarm) begin
      ns = 2; m_left = 0;
      m_view = set_time ? 3'b000 : set_cal ? 3'b100 : 3'b010;
    end else if (m_state == 2) begin
      ns = 0; m_view = 0;
    end else if (ce || ae) begin
      ns = 1; m_left = H; m_view = ce ? 3'b100 : 3'b010;
    end else if (m_state == 3 && uart_upd) begin
      m_left = H;
    end else if (m_state == 0 && (uart_upd || m_pend)) begin
      ns = 3; m_left = H; m_view = 3'b001;
    end else if (m_left == 1) begin
      ns = 0; m_left = 0; m_view = 0;
    end else if (m_left > 1) begin
      m_left--;
    end
    if (ns == 3 && m_state != 3) m_pend = 0;
    else if (uart_upd && ns != 3) m_pend = 1;
    m_state = ns;
    pk_cal = key_cal;
    pk_alm = key_alm;
    m_sel = m_view;
`ifdef DISP_ALARM_RING_EN
    if (!alarm_ring) begin m_blink = 0; m_bc = 0; end
    else if (m_bc == B - 1) begin m_bc = 0; m_blink = !m_blink; end
    else m_bc++;
    if (alarm_ring && ns != 2) m_sel = 3'b010;
`endif
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".sel"}, sel, m_sel);
    chk({tag, ".state"}, state, m_state);
    chk({tag, ".busy"}, hold_busy, m_left > 0);
`ifdef DISP_ALARM_RING_EN
    chk({tag, ".blink"}, blink, m_blink);
`endif
  endtask
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask
  task automatic cycn(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1;
    cyc("release");
    key_cal = 0; cycn("peek_cal", 2);
    key_cal = 1; cycn("peek_cal", 10);
    key_cal = 0; cycn("held_key", 12);
    key_cal = 1; cyc("held_key");
    key_cal = 0; cycn("retarget", 3);
    key_alm = 0; cycn("retarget", 10);
    key_cal = 1; key_alm = 1; cyc("both");
    key_cal = 0; key_alm = 0; cycn("both", 2);
    key_cal = 1; key_alm = 1; cycn("both", 9);
    key_cal = 0; cycn("abort", 2);
    set_cal = 1; set_time = 1; cycn("set_prio", 2);
    set_time = 0; cycn("set_cal", 2);
    set_cal = 0; cycn("set_exit", 2);
    key_cal = 1;
    set_alarm = 1; cyc("pend");
    uart_upd = 1; cyc("pend");
    uart_upd = 0; cycn("pend", 2);
    uart_upd = 1; cyc("pend");
    uart_upd = 0; cyc("pend");
    set_alarm = 0; cycn("banner", 13);
    uart_upd = 1; cyc("banner2");
    uart_upd = 0; cycn("banner2", 3);
    #2 reset = 0;
    #1 model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1;
    cycn("no_banner", 12);
`ifdef DISP_ALARM_RING_EN
    alarm_ring = 1; cycn("ring", 8);
    set_time = 1; cycn("ring_set", 2);
    set_time = 0; alarm_ring = 0; cycn("ring_off", 3);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) key_cal = !key_cal;
      if ($urandom_range(15) == 0) key_alm = !key_alm;
      if ($urandom_range(59) == 0) set_time = !set_time;
      if ($urandom_range(59) == 0) set_cal = !set_cal;
      if ($urandom_range(59) == 0) set_alarm = !set_alarm;
      uart_upd = $urandom_range(19) == 0;
`ifdef DISP_ALARM_RING_EN
      if ($urandom_range(49) == 0) alarm_ring = !alarm_ring;
`endif
      if ($urandom_range(499) == 0) begin
        #2 reset = 0;
        #1 model_reset();
        check_all("rand_reset");
        @(negedge clk);
        reset = 1;
      end
      cyc("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
